// File: rtl/signed_divider_pkg.sv
// -----------------------------------------------------------------------------
// signed_divider_pkg
// Shared definitions for the signed restoring divider:
//   - state_t : controller states (IDLE, CALC, FIX), 2-bit encoding
//   - DW_DEF  : default dividend/quotient width
//   - VW_DEF  : default divisor/remainder width
//   - Q_OVF   : quotient returned for the -2^(DW-1) / -1 overflow case
// No ports (package).
// -----------------------------------------------------------------------------
package signed_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;

  localparam logic [7:0] Q_OVF = 8'h80;

endpackage : signed_divider_pkg

// File: rtl/signed_divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step on magnitudes.
// Ports:
//   i_rem  [VW-1:0] partial remainder before the step (always < i_dvs)
//   i_bit           next dividend bit shifted into the remainder
//   i_dvs  [VW:0]   divisor magnitude (VW+1 bits so that 2^(VW-1) fits)
//   o_rem  [VW-1:0] partial remainder after the step
//   o_qbit          quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
  parameter int VW = 4
) (
  input  logic [VW-1:0] i_rem,
  input  logic          i_bit,
  input  logic [VW:0]   i_dvs,
  output logic [VW-1:0] o_rem,
  output logic          o_qbit
);

  logic [VW:0] w_shifted;
  logic        w_ge;

  assign w_shifted = {i_rem, i_bit};
  assign w_ge      = (w_shifted >= i_dvs);

  // Whichever value is kept is strictly below the divisor magnitude, which is
  // at most 2^(VW-1), so it always fits in VW bits.
  assign o_rem  = w_ge ? VW'(w_shifted - i_dvs) : w_shifted[VW-1:0];
  assign o_qbit = w_ge;

endmodule : div_step

// File: rtl/signed_divider.sv
// -----------------------------------------------------------------------------
// signed_divider
// Multi-cycle truncating signed divider (sign-magnitude restoring method,
// one quotient bit per clock, MSB first, sign correction in a final cycle).
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   start         request a division (sampled only while idle)
//   n    [DW-1:0] signed dividend
//   m    [VW-1:0] signed divisor
//   busy          division in progress
//   done          one-cycle pulse, results valid
//   q    [DW-1:0] signed quotient (held until next done)
//   r    [VW-1:0] signed remainder (held until next done)
//   dbz           divide-by-zero flag of the last division
//   ovf           quotient-overflow flag of the last division
// -----------------------------------------------------------------------------
module signed_divider
  import signed_divider_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] n,
  input  logic [VW-1:0] m,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] q,
  output logic [VW-1:0] r,
  output logic          dbz,
  output logic          ovf
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  state_t        r_state;
  state_t        w_state_next;

  // r_dvd starts as |n| and shifts left each step; quotient bits enter at the
  // LSB, so after DW steps it holds the quotient magnitude.
  logic [DW-1:0] r_dvd;
  logic [VW:0]   r_dvs;
  logic [VW-1:0] r_rem;
  logic [CW-1:0] r_cnt;
  logic          r_neg_n;
  logic          r_neg_q;
  logic          r_dbz_f;
  logic          r_ovf_f;

  logic          r_done;
  logic [DW-1:0] r_q;
  logic [VW-1:0] r_r;
  logic          r_dbz;
  logic          r_ovf;

  logic [DW-1:0] w_n_mag;
  logic [VW:0]   w_m_ext;
  logic [VW:0]   w_m_mag;
  logic          w_m_zero;
  logic          w_ovf_case;
  logic [VW-1:0] w_rem_next;
  logic          w_q_bit;

  // -2^(DW-1) negates to itself, which read as unsigned is the correct magnitude.
  assign w_n_mag    = n[DW-1] ? -n : n;
  assign w_m_ext    = {m[VW-1], m};
  assign w_m_mag    = m[VW-1] ? -w_m_ext : w_m_ext;
  assign w_m_zero   = (m == '0);
  assign w_ovf_case = (n == {1'b1, {(DW-1){1'b0}}}) && (m == '1);

  div_step #(.VW(VW)) u_div_step (
    .i_rem  (r_rem),
    .i_bit  (r_dvd[DW-1]),
    .i_dvs  (r_dvs),
    .o_rem  (w_rem_next),
    .o_qbit (w_q_bit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = w_m_zero ? FIX : CALC;
        end
      end
      CALC: begin
        if (r_cnt == CW'(DW - 1)) begin
          w_state_next = FIX;
        end
      end
      FIX:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_neg_n <= 1'b0;
      r_neg_q <= 1'b0;
      r_dbz_f <= 1'b0;
      r_ovf_f <= 1'b0;
      r_done  <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_dvd   <= w_n_mag;
            r_dvs   <= w_m_mag;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_neg_n <= n[DW-1];
            r_neg_q <= n[DW-1] ^ m[VW-1];
            r_dbz_f <= w_m_zero;
            r_ovf_f <= w_ovf_case;
          end
        end
        CALC: begin
          r_dvd <= {r_dvd[DW-2:0], w_q_bit};
          r_rem <= w_rem_next;
          r_cnt <= r_cnt + CW'(1);
        end
        FIX: begin
          r_done <= 1'b1;
          r_dbz  <= r_dbz_f;
          r_ovf  <= r_ovf_f;
          // Overflow needs no special path: both signs are negative, so the
          // unnegated magnitude 2^(DW-1) is returned as the 1000..0 pattern.
          if (r_dbz_f) begin
            r_q <= '0;
            r_r <= '0;
          end else begin
            r_q <= r_neg_q ? -r_dvd : r_dvd;
            r_r <= r_neg_n ? -r_rem : r_rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign q    = r_q;
  assign r    = r_r;
  assign dbz  = r_dbz;
  assign ovf  = r_ovf;

endmodule : signed_divider

// File: tb/tb_signed_divider.sv
// -----------------------------------------------------------------------------
// tb_signed_divider
// Directed table of divisions, hand-written sequencing / reset scenarios and
// an exhaustive sweep of all (n, m) pairs against a truncating-division model.
// -----------------------------------------------------------------------------
module tb_signed_divider;
  import signed_divider_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] n;
  logic [3:0] m;
  logic       busy;
  logic       done;
  logic [7:0] q;
  logic [3:0] r;
  logic       dbz;
  logic       ovf;

  int n_tests;
  int n_fail;

  signed_divider #(.DW(8), .VW(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .n     (n),
    .m     (m),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dbz   (dbz),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] n;
    logic [3:0] m;
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    logic       ovf;
    int         lat;
  } vec_t;

  vec_t vecs [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", name, act);
    end
  endtask

  // Start a division in the current cycle (cycle 0) and wait for done.
  // lat is the cycle number in which done is seen; 0 means it never came.
  task automatic do_div(input logic [7:0] a, input logic [3:0] b, output int lat);
    n     = a;
    m     = b;
    start = 1'b1;
    step();
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 40) begin
      step();
      lat++;
    end
    if (!done) lat = 0;
  endtask

  initial begin
    int  lat;
    int  cyc;
    bit  seen_done;

    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    n       = '0;
    m       = '0;

    vecs[0]  = '{8'd56,   4'd7,   8'd8,    4'd0,   1'b0, 1'b0, 10};
    vecs[1]  = '{8'd43,   4'hB,   8'hF8,   4'd3,   1'b0, 1'b0, 10};
    vecs[2]  = '{8'hD5,   4'd5,   8'hF8,   4'hD,   1'b0, 1'b0, 10};
    vecs[3]  = '{8'd100,  4'd0,   8'd0,    4'd0,   1'b1, 1'b0, 2};
    vecs[4]  = '{8'h80,   4'hF,   Q_OVF,   4'd0,   1'b0, 1'b1, 10};
    vecs[5]  = '{8'hC8,   4'h8,   8'd7,    4'd0,   1'b0, 1'b0, 10};
    vecs[6]  = '{8'd127,  4'h8,   8'hF1,   4'd7,   1'b0, 1'b0, 10};
    vecs[7]  = '{8'h80,   4'd7,   8'hEE,   4'hE,   1'b0, 1'b0, 10};
    vecs[8]  = '{8'd0,    4'hD,   8'd0,    4'd0,   1'b0, 1'b0, 10};
    vecs[9]  = '{8'd5,    4'hF,   8'hFB,   4'd0,   1'b0, 1'b0, 10};
    vecs[10] = '{8'hFF,   4'd2,   8'd0,    4'hF,   1'b0, 1'b0, 10};

    // Reset state
    step(); step(); step();
    rst = 1'b0;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset q",    64'(q),    64'd0);
    check("reset r",    64'(r),    64'd0);
    check("reset dbz",  64'(dbz),  64'd0);
    check("reset ovf",  64'(ovf),  64'd0);

    // Directed table
    for (int i = 0; i < 11; i++) begin
      do_div(vecs[i].n, vecs[i].m, lat);
      $display("[TB] vec %0d: n=%0d m=%0d -> q=%0d r=%0d dbz=%0b ovf=%0b at cycle %0d",
               i, $signed(vecs[i].n), $signed(vecs[i].m), $signed(q), $signed(r), dbz, ovf, lat);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d q", i),   64'(q),   64'(vecs[i].q));
      check($sformatf("vec%0d r", i),   64'(r),   64'(vecs[i].r));
      check($sformatf("vec%0d dbz", i), 64'(dbz), 64'(vecs[i].dbz));
      check($sformatf("vec%0d ovf", i), 64'(ovf), 64'(vecs[i].ovf));
      step();
      check($sformatf("vec%0d done one cycle", i), 64'(done), 64'd0);
      check($sformatf("vec%0d q held", i), 64'(q), 64'(vecs[i].q));
    end

    // Sequencing: start ignored while busy, inputs changed mid-flight,
    // start in the done cycle accepted
    n = 8'hC8; m = 4'h8; start = 1'b1;
    step();
    cyc = 1;
    start = 1'b0; n = 8'h11; m = 4'h1;
    check("seq busy cycle1", 64'(busy), 64'd1);
    while (cyc < 4) begin step(); cyc++; end
    n = 8'd100; m = 4'd0; start = 1'b1;
    step(); cyc++;
    start = 1'b0;
    while (!done && cyc < 40) begin step(); cyc++; end
    check("seq first done cycle", 64'(cyc), 64'd10);
    check("seq first q", 64'(q), 64'd7);
    check("seq first r", 64'(r), 64'd0);
    check("seq first dbz", 64'(dbz), 64'd0);
    n = 8'd56; m = 4'd7; start = 1'b1;
    step(); cyc++;
    start = 1'b0;
    while (!done && cyc < 50) begin step(); cyc++; end
    check("seq second done cycle", 64'(cyc), 64'd20);
    check("seq second q", 64'(q), 64'd8);
    check("seq second r", 64'(r), 64'd0);
    $display("[TB] seq: back-to-back done at cycle %0d q=%0d", cyc, $signed(q));

    // Reset mid-operation
    n = 8'd64; m = 4'd3; start = 1'b1;
    step();
    cyc = 1;
    start = 1'b0;
    while (cyc < 5) begin step(); cyc++; end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst q cleared", 64'(q), 64'd0);
    seen_done = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (done) seen_done = 1'b1;
      step();
    end
    check("midrst no done", 64'(seen_done), 64'd0);
    do_div(8'd64, 4'd3, lat);
    check("after rst latency", 64'(lat), 64'd10);
    check("after rst q", 64'(q), 64'd21);
    check("after rst r", 64'(r), 64'd1);
    $display("[TB] midrst: 64/3 -> q=%0d r=%0d", $signed(q), $signed(r));

    // Reset wins over start
    n = 8'd56; m = 4'd7; start = 1'b1; rst = 1'b1;
    step();
    start = 1'b0; rst = 1'b0;
    check("rst priority busy", 64'(busy), 64'd0);
    seen_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done || busy) seen_done = 1'b1;
      step();
    end
    check("rst priority no op", 64'(seen_done), 64'd0);

    // Exhaustive signed sweep against a behavioural model
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 16; j++) begin
        logic [7:0] nv;
        logic [3:0] mv;
        int a, b, eq, er, el;
        logic edbz, eovf;
        nv = i[7:0];
        mv = j[3:0];
        a  = int'($signed(nv));
        b  = int'($signed(mv));
        edbz = 1'b0;
        eovf = 1'b0;
        el   = 10;
        if (b == 0) begin
          eq = 0; er = 0; edbz = 1'b1; el = 2;
        end else if (a == -128 && b == -1) begin
          eq = 128; er = 0; eovf = 1'b1;
        end else begin
          eq = a / b;
          er = a % b;
        end
        do_div(nv, mv, lat);
        check($sformatf("sweep n=%0d m=%0d {lat,q,r,dbz,ovf}", a, b),
              {44'd0, 8'(lat), q, r, dbz, ovf},
              {44'd0, 8'(el), 8'(eq), 4'(er), edbz, eovf});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_signed_divider
